prog_timer_counter: RTL and testbench
=====================================

// Module: prog_timer_counter
// PURPOSE
//  Parametrised programmable counter/timer, next generation of our 3-bit loadable down-counter.
//  Adds configurable width, a programmable prescaler, up/down direction and one-shot vs
//  auto-reload modes, a sticky done flag and a one-cycle terminal-count pulse.
//  Used as a general event/period timer by control FSMs; one clock domain.
// PARAMETERS
//  WIDTH       8  count / load value width (>=1)
//  PRESCALE_W  4  prescale field width; step every (prescale+1) enabled cycles
// PORTS
//  clk        in   1           rising-edge clock (single clock)
//  reset_n    in   1           asynchronous, active-low reset
//  load       in   1           latch load_val/mode/prescale, (re)start run
//  load_val   in   WIDTH       terminal/start value
//  mode       in   2           00 one-shot down, 01 reload down, 10 one-shot up, 11 reload up
//  prescale   in   PRESCALE_W  prescale divisor minus one
//  count_en   in   1           enable; low freezes count and prescaler
//  count      out  WIDTH       current count
//  done       out  1           sticky: one-shot reached terminal; cleared by load/reset
//  tc_pulse   out  1           1-cycle pulse per terminal step (both modes)
//  busy       out  1           1 while state==RUN
// BEHAVIOUR
//  Reset (async, any time incl. mid-run): state=IDLE, count=0, done=0, tc_pulse=0, busy=0,
//   prescaler=0, latched term/mode/prescale=0.
//  States: IDLE, RUN, DONE. IDLE/DONE ignore count_en; load from any state -> RUN.
//  load at edge k: term_q=load_val, mode_q=mode, pre_q=prescale; count=load_val (down)
//   or 0 (up); prescaler=0; done=0; tc_pulse=0. Values visible after edge k.
//  mode/prescale/load_val are sampled only on load; changes mid-run are ignored.
//  Prescaler advances only when RUN && count_en; step = count_en && prescaler==pre_q,
//   prescaler wraps to 0 on step. pre_q=0 -> step every enabled cycle.
//  Target: 0 (down), term_q (up). On step:
//   count!=target: count -/+ 1 (no wrap possible before target).
//   count==target, one-shot: count held, done=1, tc_pulse=1, state -> DONE.
//   count==target, reload: count = term_q (down) / 0 (up), tc_pulse=1, stay RUN, done stays 0.
//  tc_pulse high exactly the cycle after the terminal-step edge, else 0.
//  load_val=0: first step is terminal (one-shot done after 1 step; reload tc every step).
//  load and step same cycle: load wins; no tc_pulse, no done.
//  Latency: load->first step = pre_q+1 enabled cycles; one-shot down from N: done after
//   (N+1)*(pre_q+1) enabled cycles.
// STRUCTURE
//  Shared package counter_pkg: MODE_ONESHOT_DOWN/RELOAD_DOWN/ONESHOT_UP/RELOAD_UP
//   2-bit localparams; state encodings ST_IDLE/ST_RUN/ST_DONE.
//  Sub-module counter_prescaler #(PRESCALE_W): inputs clk, reset_n, clr (=load), en,
//   div; output tick. Top holds FSM, count, term/mode regs, done, tc_pulse.
// TESTING
//  1 WIDTH=8, mode 00, load_val=3, prescale=0, en=1 -> count 3,2,1,0; next edge done=1,
//    tc_pulse=1 one cycle, busy=0, count holds 0.
//  2 mode 01, load_val=2 -> count 2,1,0,2,1,0...; tc_pulse every 3rd cycle; done stays 0.
//  3 mode 10, load_val=4, prescale=2 -> count steps every 3 enabled cycles 0..4 then done;
//    drop count_en 5 cycles mid-run -> count and prescaler frozen, timing resumes exactly.
//  4 load (load_val=5) on same cycle as terminal step -> count=5, no tc_pulse, done=0.
//  5 reset_n low mid-run (count=7) -> count=0, done=0, busy=0 immediately; en in IDLE ignored.
//  6 mode 11, load_val=255 -> 0..255 then 0 with tc_pulse; mode 00 load_val=0 -> done
//    after 1 enabled cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the programmable counter/timer: count modes and FSM states.
package counter_pkg;

   localparam logic [1:0] MODE_ONESHOT_DOWN = 2'b00;
   localparam logic [1:0] MODE_RELOAD_DOWN  = 2'b01;
   localparam logic [1:0] MODE_ONESHOT_UP   = 2'b10;
   localparam logic [1:0] MODE_RELOAD_UP    = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Mode bit 1 selects direction, bit 0 selects auto-reload.
   function automatic logic mode_is_up(input logic [1:0] m);
      return m[1];
   endfunction

   function automatic logic mode_is_reload(input logic [1:0] m);
      return m[0];
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler: raises tick on every (div+1)-th enabled cycle; clr restarts the phase.
module counter_prescaler #(
   parameter int unsigned PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] div,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] phase;

   assign tick = en && (phase == div);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase <= '0;
      end else if (clr) begin
         phase <= '0;
      end else if (en) begin
         phase <= tick ? '0 : phase + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/prog_timer_counter.sv
// Programmable up/down counter/timer with prescaler, one-shot or auto-reload operation,
// sticky done flag and a one-cycle terminal-count pulse.
module prog_timer_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned PRESCALE_W = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic [1:0]            mode,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  count_en,
   output logic [WIDTH-1:0]      count,
   output logic                  done,
   output logic                  tc_pulse,
   output logic                  busy
);

   logic [1:0]            state, state_d;
   logic [WIDTH-1:0]      count_d;
   logic                  done_d, tc_d;
   logic [WIDTH-1:0]      term_q;
   logic [1:0]            mode_q;
   logic [PRESCALE_W-1:0] pre_q;
   logic                  step;
   logic [WIDTH-1:0]      target;

   counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (load),
      .en      ((state == ST_RUN) && count_en),
      .div     (pre_q),
      .tick    (step)
   );

   assign target = mode_is_up(mode_q) ? term_q : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         count    <= '0;
         done     <= 1'b0;
         tc_pulse <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         count    <= count_d;
         done     <= done_d;
         tc_pulse <= tc_d;
         busy     <= (state_d == ST_RUN);
      end
   end

   // Run configuration is captured only on load and held for the whole run.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         term_q <= '0;
         mode_q <= MODE_ONESHOT_DOWN;
         pre_q  <= '0;
      end else if (load) begin
         term_q <= load_val;
         mode_q <= mode;
         pre_q  <= prescale;
      end
   end

   // Next state: load overrides any step taken in the same cycle.
   always_comb begin
      state_d = state;
      count_d = count;
      done_d  = done;
      tc_d    = 1'b0;
      if (load) begin
         state_d = ST_RUN;
         count_d = mode_is_up(mode) ? '0 : load_val;
         done_d  = 1'b0;
      end else if ((state == ST_RUN) && step) begin
         if (count != target) begin
            count_d = mode_is_up(mode_q) ? count + WIDTH'(1) : count - WIDTH'(1);
         end else if (mode_is_reload(mode_q)) begin
            count_d = mode_is_up(mode_q) ? '0 : term_q;
            tc_d    = 1'b1;
         end else begin
            done_d  = 1'b1;
            tc_d    = 1'b1;
            state_d = ST_DONE;
         end
      end
   end

endmodule

// File: tb/tb_prog_timer_counter.sv
// Self-checking bench for prog_timer_counter: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural timer model.
module tb_prog_timer_counter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       load;
   logic [7:0] load_val;
   logic [1:0] mode;
   logic [3:0] prescale;
   logic       count_en;
   logic [7:0] count;
   logic       done;
   logic       tc_pulse;
   logic       busy;

   int total = 0;
   int bad   = 0;

   // Model: run flag + phase counter, counting expressed with plain arithmetic.
   int m_state;   // 0 idle, 1 run, 2 done
   int m_count, m_term, m_mode, m_pre, m_phase;
   bit m_done, m_tc;

   prog_timer_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load),
      .load_val (load_val),
      .mode     (mode),
      .prescale (prescale),
      .count_en (count_en),
      .count    (count),
      .done     (done),
      .tc_pulse (tc_pulse),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 0; m_count = 0; m_term = 0; m_mode = 0; m_pre = 0; m_phase = 0;
      m_done = 0; m_tc = 0;
   endtask

   task automatic model_edge();
      bit up;
      m_tc = 0;
      if (load) begin
         m_term = load_val; m_mode = mode; m_pre = prescale; m_phase = 0;
         m_count = mode[1] ? 0 : int'(load_val);
         m_done = 0; m_state = 1;
      end else if (m_state == 1 && count_en) begin
         if (m_phase < m_pre) begin
            m_phase++;
         end else begin
            m_phase = 0;
            up = (m_mode >= 2);
            if (up && m_count < m_term) m_count++;
            else if (!up && m_count > 0) m_count--;
            else begin
               m_tc = 1;
               if (m_mode % 2 == 1) m_count = up ? 0 : m_term;
               else begin m_done = 1; m_state = 2; end
            end
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_load(input logic [7:0] v, input logic [1:0] m, input logic [3:0] p);
      load = 1'b1; load_val = v; mode = m; prescale = p;
      cyc();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; load = 0; load_val = 0; mode = 0; prescale = 0; count_en = 0;
      model_reset();
      #12;
      total++;
      if (count !== 8'd0 || done !== 1'b0 || tc_pulse !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset: count=%0d done=%b tc=%b busy=%b required 0/0/0/0",
                  count, done, tc_pulse, busy);
      end
      @(negedge clk); reset_n = 1'b1;
      count_en = 1'b1;
      repeat (3) cyc();
      total++;
      if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL idle_ignores_en: count=%0d busy=%b done=%b required 0/0/0",
                  count, busy, done);
      end
   endtask

   task automatic test_oneshot_down();
      int exp_seq[4] = '{3, 2, 1, 0};
      count_en = 1'b1;
      set_load(8'd3, 2'b00, 4'd0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) cyc();
         total++;
         if (count !== 8'(exp_seq[i]) || busy !== 1'b1 || done !== 1'b0 || tc_pulse !== 1'b0) begin
            bad++;
            $display("FAIL oneshot_down[%0d]: count=%0d busy=%b done=%b tc=%b required %0d/1/0/0",
                     i, count, busy, done, tc_pulse, exp_seq[i]);
         end
      end
      cyc();
      total++;
      if (count !== 8'd0 || done !== 1'b1 || tc_pulse !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL oneshot_done: count=%0d done=%b tc=%b busy=%b required 0/1/1/0",
                  count, done, tc_pulse, busy);
      end
      cyc();
      total++;
      if (count !== 8'd0 || done !== 1'b1 || tc_pulse !== 1'b0) begin
         bad++;
         $display("FAIL oneshot_hold: count=%0d done=%b tc=%b required 0/1/0", count, done, tc_pulse);
      end
   endtask

   task automatic test_reload_down();
      int exp_c;
      bit exp_tc;
      count_en = 1'b1;
      set_load(8'd2, 2'b01, 4'd0);
      for (int i = 1; i <= 9; i++) begin
         cyc();
         exp_c  = 2 - (i % 3);
         exp_tc = (i % 3 == 0);
         total++;
         if (count !== 8'(exp_c) || tc_pulse !== exp_tc || done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reload_down[%0d]: count=%0d tc=%b done=%b busy=%b required %0d/%b/0/1",
                     i, count, tc_pulse, done, busy, exp_c, exp_tc);
         end
      end
   endtask

   task automatic test_prescale_up();
      count_en = 1'b1;
      set_load(8'd4, 2'b10, 4'd2);
      repeat (7) cyc();
      mode = 2'b00; prescale = 4'd0; load_val = 8'd99;   // ignored mid-run
      total++;
      if (count !== 8'd2) begin
         bad++;
         $display("FAIL prescale_pre_freeze: count=%0d required 2", count);
      end
      count_en = 1'b0;
      repeat (5) cyc();
      total++;
      if (count !== 8'd2 || busy !== 1'b1) begin
         bad++;
         $display("FAIL prescale_frozen: count=%0d busy=%b required 2/1", count, busy);
      end
      count_en = 1'b1;
      cyc();
      total++;
      if (count !== 8'd2) begin
         bad++;
         $display("FAIL prescale_resume_phase: count=%0d required 2", count);
      end
      cyc();
      total++;
      if (count !== 8'd3) begin
         bad++;
         $display("FAIL prescale_resume_step: count=%0d required 3", count);
      end
      repeat (6) cyc();
      total++;
      if (count !== 8'd4 || done !== 1'b1 || tc_pulse !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL prescale_up_done: count=%0d done=%b tc=%b busy=%b required 4/1/1/0",
                  count, done, tc_pulse, busy);
      end
   endtask

   task automatic test_load_on_terminal();
      count_en = 1'b1;
      set_load(8'd1, 2'b00, 4'd0);
      cyc();
      set_load(8'd5, 2'b00, 4'd0);
      total++;
      if (count !== 8'd5 || tc_pulse !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL load_wins: count=%0d tc=%b done=%b busy=%b required 5/0/0/1",
                  count, tc_pulse, done, busy);
      end
      cyc();
      total++;
      if (count !== 8'd4 || tc_pulse !== 1'b0) begin
         bad++;
         $display("FAIL load_wins_next: count=%0d tc=%b required 4/0", count, tc_pulse);
      end
   endtask

   task automatic test_reset_midrun();
      count_en = 1'b1;
      set_load(8'd10, 2'b00, 4'd0);
      repeat (3) cyc();
      total++;
      if (count !== 8'd7) begin
         bad++;
         $display("FAIL midrun_count: count=%0d required 7", count);
      end
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (count !== 8'd0 || done !== 1'b0 || busy !== 1'b0 || tc_pulse !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: count=%0d done=%b busy=%b tc=%b required 0/0/0/0",
                  count, done, busy, tc_pulse);
      end
      @(negedge clk); reset_n = 1'b1;
      repeat (3) cyc();
      total++;
      if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle: count=%0d busy=%b done=%b required 0/0/0",
                  count, busy, done);
      end
   endtask

   task automatic test_boundaries();
      count_en = 1'b1;
      set_load(8'd255, 2'b11, 4'd0);
      for (int i = 1; i <= 255; i++) begin
         cyc();
         total++;
         if (count !== 8'(i) || tc_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reload_up[%0d]: count=%0d tc=%b required %0d/0", i, count, tc_pulse, i);
         end
      end
      cyc();
      total++;
      if (count !== 8'd0 || tc_pulse !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL reload_up_wrap: count=%0d tc=%b done=%b busy=%b required 0/1/0/1",
                  count, tc_pulse, done, busy);
      end
      set_load(8'd0, 2'b00, 4'd0);
      total++;
      if (count !== 8'd0 || done !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL zero_load: count=%0d done=%b busy=%b required 0/0/1", count, done, busy);
      end
      cyc();
      total++;
      if (done !== 1'b1 || tc_pulse !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL zero_done: done=%b tc=%b busy=%b required 1/1/0", done, tc_pulse, busy);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         load     = ($urandom_range(0, 19) == 0);
         load_val = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
         mode     = 2'($urandom);
         prescale = 4'($urandom_range(0, 3));
         count_en = ($urandom_range(0, 3) != 0);
         cyc();
         total++;
         if (count !== 8'(m_count) || done !== m_done || tc_pulse !== m_tc ||
             busy !== (m_state == 1)) begin
            bad++;
            $display("FAIL random[%0d]: count=%0d done=%b tc=%b busy=%b required %0d/%b/%b/%b",
                     i, count, done, tc_pulse, busy, m_count, m_done, m_tc, (m_state == 1));
         end
      end
      load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_oneshot_down();
      test_reload_down();
      test_prescale_up();
      test_load_on_terminal();
      test_reset_midrun();
      test_boundaries();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
